// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction fetch front end.
//   XLEN         : architectural data/address width
//   INST_NOP     : encoding presented when no instruction is buffered (addi x0,x0,0)
//   fetchState_t : prefetch sequencer states
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    // FETCH   : normal streaming of sequential words into the buffer.
    // DISCARD : a redirect hit a stalled transfer; finish it, drop its data.
    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetchState_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with occupancy count and synchronous flush.
// Push and pop in the same cycle are both honoured, including when full.
// Flush has priority over push and pop.
// Ports:
//   i_Clk, i_Rst_n : clock, asynchronous active-low reset
//   push, wrData   : write request and data (ignored when full without pop)
//   pop            : read request (ignored when empty)
//   flush          : discard all entries
//   rdData         : head entry (undefined content when level == 0)
//   level          : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               wrData,
    output logic [WIDTH-1:0]               rdData,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             full;
    logic             empty;
    logic             doPush;
    logic             doPop;

    assign full   = level == LEVEL_W'(DEPTH);
    assign empty  = level == '0;
    assign doPop  = pop && !empty && !flush;
    // A pop frees the slot this cycle, so a push at full is still safe.
    assign doPush = push && (!full || pop) && !flush;
    assign rdData = mem[rdPtr];

    // NOTE: storage carries no reset; entries are only observed through
    // level, so clearing the pointers is enough and keeps the array as plain RAM.
    always_ff @(posedge i_Clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/prefetch_unit.sv
// -----------------------------------------------------------------------------
// prefetch_unit
// Sequential instruction prefetcher: streams words from the instruction bus
// into a small buffer, one transfer outstanding at most, and flushes/refetches
// on redirect. A redirect that lands on a stalled transfer parks the new PC
// until that transfer completes and its data is thrown away.
//
// Build option: define PREFETCH_UNIT_BYPASS_EN to forward completing bus data
// straight to the head outputs while the buffer is empty (adds a bus-to-output
// combinational path). Without it, data shows up one cycle after completion.
//
// Ports:
//   i_Clk, i_Rst_n        : clock, asynchronous active-low reset
//   i_Redirect            : flush buffer and refetch from i_RedirectPC
//   i_RedirectPC          : new byte address, bits [1:0] ignored
//   i_Consume             : pop head entry (ignored when o_Valid = 0)
//   o_Valid/o_Inst/o_PC   : head entry; NOP/0 when nothing is available
//   o_Level               : buffered entry count
//   o_IBus_Address        : word address of the current request
//   o_IBus_Read           : read request, held while i_IBus_WaitReq is high
//   i_IBus_ReadData       : read data, valid on Read=1 and WaitReq=0
//   i_IBus_WaitReq        : slave stall
// -----------------------------------------------------------------------------
module prefetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] INITIAL_PC_VALUE = 32'h0000_0000,
    parameter int              FIFO_DEPTH       = 4
) (
    input  logic                                i_Clk,
    input  logic                                i_Rst_n,
    input  logic                                i_Redirect,
    input  logic [XLEN-1:0]                     i_RedirectPC,
    input  logic                                i_Consume,
    output logic                                o_Valid,
    output logic [XLEN-1:0]                     o_Inst,
    output logic [XLEN-1:0]                     o_PC,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_Level,
    output logic [XLEN-3:0]                     o_IBus_Address,
    output logic                                o_IBus_Read,
    input  logic [XLEN-1:0]                     i_IBus_ReadData,
    input  logic                                i_IBus_WaitReq
);

    localparam int LEVEL_W = $clog2(FIFO_DEPTH+1);

    fetchState_t         state;
    fetchState_t         nextState;
    logic [XLEN-1:0]     fetchPc;
    logic [XLEN-1:0]     pendingPc;
    logic [XLEN-1:0]     redirectTarget;
    logic                readReq;
    logic                xferDone;
    logic                acceptData;
    logic                fifoPush;
    logic                fifoPop;
    logic                fifoEmpty;
    logic                fifoFull;
    logic [LEVEL_W-1:0]  fifoLevel;
    logic [2*XLEN-1:0]   fifoHead;
    logic                bypassHit;
    logic                unusedRedirectLsbs;

    assign redirectTarget     = {i_RedirectPC[XLEN-1:2], 2'b00};
    assign unusedRedirectLsbs = ^i_RedirectPC[1:0];
    assign fifoEmpty          = fifoLevel == '0;
    assign fifoFull           = fifoLevel == LEVEL_W'(FIFO_DEPTH);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) state <= FETCH;
        else          state <= nextState;
    end

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        readReq   = 1'b0;
        case (state)
            FETCH: begin
                // At full, a request is only worth issuing if a slot frees now.
                readReq = !fifoFull || i_Consume;
                if (i_Redirect && readReq && i_IBus_WaitReq) nextState = DISCARD;
            end
            DISCARD: begin
                readReq = 1'b1;
                if (!i_IBus_WaitReq) nextState = FETCH;
            end
            default: nextState = FETCH;
        endcase
    end

    // Gating with reset drops the request in the very cycle reset asserts.
    assign o_IBus_Read    = readReq && i_Rst_n;
    assign xferDone       = o_IBus_Read && !i_IBus_WaitReq;
    assign o_IBus_Address = fetchPc[XLEN-1:2];

    // fetchPc doubles as the bus address, so it must not move while a
    // transfer is stalled; the redirect target waits in pendingPc instead.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            fetchPc   <= INITIAL_PC_VALUE;
            pendingPc <= INITIAL_PC_VALUE;
        end else begin
            case (state)
                FETCH: begin
                    if (i_Redirect) begin
                        if (o_IBus_Read && i_IBus_WaitReq) pendingPc <= redirectTarget;
                        else                               fetchPc   <= redirectTarget;
                    end else if (xferDone) begin
                        fetchPc <= fetchPc + XLEN'(4);
                    end
                end
                DISCARD: begin
                    if (xferDone)        fetchPc   <= i_Redirect ? redirectTarget : pendingPc;
                    else if (i_Redirect) pendingPc <= redirectTarget;
                end
                default: fetchPc <= fetchPc;
            endcase
        end
    end

    assign acceptData = xferDone && (state == FETCH) && !i_Redirect;
    assign fifoPop    = i_Consume && !fifoEmpty && !i_Redirect;

`ifdef PREFETCH_UNIT_BYPASS_EN
    assign bypassHit = acceptData && fifoEmpty;
    // A forwarded word consumed in the same cycle never enters the buffer.
    assign fifoPush  = acceptData && !(bypassHit && i_Consume);
`else
    assign bypassHit = 1'b0;
    assign fifoPush  = acceptData;
`endif

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .push    (fifoPush),
        .pop     (fifoPop),
        .flush   (i_Redirect),
        .wrData  ({i_IBus_ReadData, fetchPc}),
        .rdData  (fifoHead),
        .level   (fifoLevel)
    );

    always_comb begin
        o_Valid = 1'b0;
        o_Inst  = INST_NOP;
        o_PC    = '0;
        if (!fifoEmpty) begin
            o_Valid = 1'b1;
            o_Inst  = fifoHead[2*XLEN-1:XLEN];
            o_PC    = fifoHead[XLEN-1:0];
        end else if (bypassHit) begin
            o_Valid = 1'b1;
            o_Inst  = i_IBus_ReadData;
            o_PC    = fetchPc;
        end
    end

    assign o_Level = fifoLevel;

endmodule

// File: tb/tb_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_prefetch_unit
// Directed scenarios for reset, streaming, fill/backpressure, redirects and
// PC wrap, followed by randomized traffic compared cycle by cycle against a
// queue-based reference model of the prefetcher.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_prefetch_unit;

    localparam logic [31:0] INIT_PC  = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam int          LW       = $clog2(DEPTH+1);
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef PREFETCH_UNIT_BYPASS_EN
    localparam bit          BYPASS   = 1'b1;
`else
    localparam bit          BYPASS   = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          redirect = 1'b0;
    logic [31:0]   redirectPc = '0;
    logic          consume = 1'b0;
    logic          valid;
    logic [31:0]   inst;
    logic [31:0]   pc;
    logic [LW-1:0] level;
    logic [29:0]   busAddr;
    logic          busRead;
    logic [31:0]   readData;
    logic          waitReq = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory contents are a fixed scramble of the address so every word is
    // distinguishable and tied to where it came from.
    function automatic logic [31:0] memWord(input logic [29:0] wordAddr);
        return ({wordAddr, 2'b00} * 32'h9E37_79B1) ^ 32'hC3C3_0F0F;
    endfunction

    assign readData = memWord(busAddr);

    prefetch_unit #(
        .INITIAL_PC_VALUE (INIT_PC),
        .FIFO_DEPTH       (DEPTH)
    ) dut (
        .i_Clk           (clk),
        .i_Rst_n         (rstN),
        .i_Redirect      (redirect),
        .i_RedirectPC    (redirectPc),
        .i_Consume       (consume),
        .o_Valid         (valid),
        .o_Inst          (inst),
        .o_PC            (pc),
        .o_Level         (level),
        .o_IBus_Address  (busAddr),
        .o_IBus_Read     (busRead),
        .i_IBus_ReadData (readData),
        .i_IBus_WaitReq  (waitReq)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges, releases it 1 unit after an edge with the
    // given bus/consume settings already applied.
    task automatic doReset(input logic cons, input logic wr);
        step();
        rstN = 1'b0; redirect = 1'b0; consume = cons; waitReq = wr;
        repeat (2) step();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        step();
        rstN = 1'b0; redirect = 1'b0; consume = 1'b0; waitReq = 1'b0;
        @(negedge clk);
        checks++; if (busRead !== 1'b0) begin errors++; $display("FAIL reset_read: got %0b want 0", busRead); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid); end
        checks++; if (level !== LW'(0)) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (busAddr !== INIT_PC[31:2]) begin errors++; $display("FAIL reset_addr: got %0h want %0h", busAddr, INIT_PC[31:2]); end
        checks++; if (inst !== NOP) begin errors++; $display("FAIL reset_inst: got %0h want %0h", inst, NOP); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %0h want 0", pc); end
        step();
        rstN = 1'b1;
        @(negedge clk);
        checks++; if (busRead !== 1'b1) begin errors++; $display("FAIL first_read: got %0b want 1", busRead); end
        checks++; if (busAddr !== INIT_PC[31:2]) begin errors++; $display("FAIL first_addr: got %0h want %0h", busAddr, INIT_PC[31:2]); end
    endtask

    task automatic test_stream();
        logic [31:0] wantPc;
        doReset(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (busAddr !== 30'(k) || busRead !== 1'b1) begin errors++; $display("FAIL stream_addr[%0d]: got %0h/%0b want %0h/1", k, busAddr, busRead, k); end
            if (BYPASS || k >= 1) begin
                wantPc = BYPASS ? 32'(4*k) : 32'(4*(k-1));
                checks++; if (valid !== 1'b1 || pc !== wantPc) begin errors++; $display("FAIL stream_pc[%0d]: got %0h valid %0b want %0h", k, pc, valid, wantPc); end
            end
            step();
        end
        consume = 1'b0;
    endtask

    task automatic test_fill();
        int xfers = 0;
        doReset(1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busRead && !waitReq) xfers++;
            step();
        end
        @(negedge clk);
        checks++; if (xfers !== 4) begin errors++; $display("FAIL fill_xfers: got %0d want 4", xfers); end
        checks++; if (level !== LW'(4)) begin errors++; $display("FAIL fill_level: got %0d want 4", level); end
        checks++; if (busRead !== 1'b0) begin errors++; $display("FAIL fill_read_idle: got %0b want 0", busRead); end
        step();
        consume = 1'b1;
        xfers = 0;
        @(negedge clk);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL fill_head: got %0h want 0", pc); end
        if (busRead && !waitReq) xfers++;
        step();
        consume = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busRead && !waitReq) xfers++;
            step();
        end
        @(negedge clk);
        checks++; if (xfers !== 1) begin errors++; $display("FAIL refill_xfers: got %0d want 1", xfers); end
        checks++; if (level !== LW'(4) || pc !== 32'h4) begin errors++; $display("FAIL refill_state: got level %0d pc %0h want 4/4", level, pc); end
    endtask

    task automatic test_redirect_stall();
        doReset(1'b0, 1'b0);
        redirect = 1'b1; redirectPc = 32'h0000_0040;
        step();
        redirect = 1'b0; waitReq = 1'b1;
        for (int s = 0; s < 4; s++) begin
            if (s == 1) begin redirect = 1'b1; redirectPc = 32'h0000_0200; end
            if (s == 2) redirect = 1'b0;
            if (s == 3) waitReq = 1'b0;
            @(negedge clk);
            checks++; if (busAddr !== 30'h10 || busRead !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got %0h/%0b want 10/1", s, busAddr, busRead); end
            checks++; if (level !== LW'(0)) begin errors++; $display("FAIL stall_level[%0d]: got %0d want 0", s, level); end
            step();
        end
        waitReq = 1'b1;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            checks++; if (busAddr !== 30'h80) begin errors++; $display("FAIL discard_next_addr[%0d]: got %0h want 80", s, busAddr); end
            checks++; if (level !== LW'(0) || valid !== 1'b0) begin errors++; $display("FAIL discard_dropped[%0d]: got level %0d valid %0b want 0/0", s, level, valid); end
            step();
        end
        waitReq = 1'b0;
    endtask

    task automatic test_redirect_complete();
        doReset(1'b0, 1'b0);
        repeat (3) step();
        redirect = 1'b1; redirectPc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (level !== LW'(0) || busAddr !== 30'h40) begin errors++; $display("FAIL redir_done_flush: got level %0d addr %0h want 0/40", level, busAddr); end
        step();
        @(negedge clk);
        checks++; if (valid !== 1'b1 || pc !== 32'h100 || inst !== memWord(30'h40)) begin errors++; $display("FAIL redir_done_head: got pc %0h inst %0h valid %0b want 100/%0h/1", pc, inst, valid, memWord(30'h40)); end
    endtask

    task automatic test_wrap();
        doReset(1'b0, 1'b0);
        redirect = 1'b1; redirectPc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (busAddr !== 30'h3FFF_FFFF) begin errors++; $display("FAIL wrap_last: got %0h want 3fffffff", busAddr); end
        step();
        @(negedge clk);
        checks++; if (busAddr !== 30'h0) begin errors++; $display("FAIL wrap_zero: got %0h want 0", busAddr); end
        step();
        @(negedge clk);
        checks++; if (level !== LW'(2) || pc !== 32'hFFFF_FFFC || inst !== memWord(30'h3FFF_FFFF)) begin errors++; $display("FAIL wrap_head: got level %0d pc %0h inst %0h", level, pc, inst); end
    endtask

    task automatic test_reset_mid();
        doReset(1'b0, 1'b0);
        repeat (2) step();
        waitReq = 1'b1;
        @(negedge clk);
        checks++; if (busRead !== 1'b1 || busAddr !== 30'h2) begin errors++; $display("FAIL midrst_stall: got %0b/%0h want 1/2", busRead, busAddr); end
        #1 rstN = 1'b0;
        #1;
        checks++; if (busRead !== 1'b0) begin errors++; $display("FAIL midrst_abort: got %0b want 0", busRead); end
        step();
        rstN = 1'b1;
        @(negedge clk);
        checks++; if (busRead !== 1'b1 || busAddr !== INIT_PC[31:2] || level !== LW'(0) || valid !== 1'b0) begin errors++; $display("FAIL midrst_restart: got read %0b addr %0h level %0d valid %0b", busRead, busAddr, level, valid); end
        waitReq = 1'b0;
    endtask

    // Reference model: what the prefetcher holds, in spec terms.
    logic [63:0] mQ[$];
    logic [31:0] mFetchPc;
    logic [31:0] mPendPc;
    bit          mDiscarding;

    task automatic test_random();
        bit          eRead, eValid, done, byp;
        logic [31:0] eInst, ePc, tgt;
        doReset(1'b0, 1'b0);
        mQ.delete(); mFetchPc = INIT_PC; mPendPc = INIT_PC; mDiscarding = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            eRead  = mDiscarding || (mQ.size() < DEPTH) || (mQ.size() == DEPTH && consume);
            done   = eRead && !waitReq;
            byp    = BYPASS && mQ.size() == 0 && done && !mDiscarding && !redirect;
            eValid = (mQ.size() > 0) || byp;
            if (mQ.size() > 0) begin eInst = mQ[0][63:32]; ePc = mQ[0][31:0]; end
            else if (byp)      begin eInst = memWord(mFetchPc[31:2]); ePc = mFetchPc; end
            else               begin eInst = NOP; ePc = 32'h0; end
            checks++; if (busRead !== eRead) begin errors++; $display("FAIL rnd_read @%0d: got %0b want %0b", cyc, busRead, eRead); end
            checks++; if (busAddr !== mFetchPc[31:2]) begin errors++; $display("FAIL rnd_addr @%0d: got %0h want %0h", cyc, busAddr, mFetchPc[31:2]); end
            checks++; if (valid !== eValid) begin errors++; $display("FAIL rnd_valid @%0d: got %0b want %0b", cyc, valid, eValid); end
            checks++; if (level !== LW'(mQ.size())) begin errors++; $display("FAIL rnd_level @%0d: got %0d want %0d", cyc, level, mQ.size()); end
            checks++; if (inst !== eInst || pc !== ePc) begin errors++; $display("FAIL rnd_head @%0d: got %0h/%0h want %0h/%0h", cyc, inst, pc, eInst, ePc); end
            if (redirect) begin
                tgt = {redirectPc[31:2], 2'b00};
                mQ.delete();
                if (mDiscarding) begin
                    if (done) begin mDiscarding = 0; mFetchPc = tgt; end
                    else mPendPc = tgt;
                end else if (eRead && waitReq) begin
                    mDiscarding = 1; mPendPc = tgt;
                end else begin
                    mFetchPc = tgt;
                end
            end else if (mDiscarding) begin
                if (done) begin mDiscarding = 0; mFetchPc = mPendPc; end
            end else begin
                if (done) begin
                    mQ.push_back({memWord(mFetchPc[31:2]), mFetchPc});
                    mFetchPc = mFetchPc + 32'd4;
                end
                if (consume && eValid) void'(mQ.pop_front());
            end
            step();
            consume    = 1'($urandom_range(0, 1));
            waitReq    = ($urandom_range(0, 9) < 3);
            redirect   = ($urandom_range(0, 11) == 0);
            redirectPc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        end
        redirect = 1'b0; consume = 1'b0; waitReq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_redirect_stall();
        test_redirect_complete();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
